// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions.
// Contents:
//   XLEN          - architectural register/address width (32)
//   NOP           - canonical no-op instruction (addi x0, x0, 0)
//   fetch_state_e - fetch FSM states (RUN, TRAP_HOLD)
//   ifid_t        - IF/ID pipeline register payload
//   word_align    - clears the two low address bits
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN       = 1'b0,
    TRAP_HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            trap;
  } ifid_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage and imem.
// Signals:
//   imem_raddr - word-aligned read address (fetch -> imem)
//   imem_rdata - instruction word, combinational for imem_raddr (imem -> fetch)
// Modports: master (fetch side), slave (memory side).
interface fetch_stage_if;
  import rv32i_pkg::*;

  logic [XLEN-1:0] imem_raddr;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_raddr, input  imem_rdata);
  modport slave  (input  imem_raddr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_ifid_pipe_reg.sv
// IF/ID pipeline register.
// Ports:
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_clear      - kill entry: valid=0, inst=NOP, trap=0 (pc/pc4 kept)
//   i_load       - capture i_d
//   i_d, o_q     - next / current entry
// Priority: reset > clear > load > hold.
module ifid_pipe_reg
  import rv32i_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_load,
  input  logic  i_clear,
  input  ifid_t i_d,
  output ifid_t o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q.valid <= 1'b0;
      o_q.inst  <= NOP;
      o_q.pc    <= '0;
      o_q.pc4   <= '0;
      o_q.trap  <= 1'b0;
    end else if (i_clear) begin
      o_q.valid <= 1'b0;
      o_q.inst  <= NOP;
      o_q.trap  <= 1'b0;
    end else if (i_load) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC register, redirect/stall/flush control
// and the IF/ID pipeline register.
// Ports:
//   i_clk, i_rst           - clock, synchronous active-high reset
//   imem                   - imem read bus (fetch_stage_if.master)
//   i_stall                - decode cannot accept; hold PC and IF/ID
//   i_flush                - kill the current IF/ID entry
//   i_redirect_valid/_pc   - taken branch/jump target from downstream
//   o_id_valid/inst/pc/pc4 - IF/ID entry
//   o_id_trap              - misaligned fetch-target trap flag
// Parameter: RESET_ADDR - PC loaded on reset.
// Build option: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect
// targets; otherwise the low target bits are silently cleared.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  fetch_stage_if.master       imem,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_redirect_valid,
  input  logic [XLEN-1:0]     i_redirect_pc,
  output logic                o_id_valid,
  output logic [XLEN-1:0]     o_id_inst,
  output logic [XLEN-1:0]     o_id_pc,
  output logic [XLEN-1:0]     o_id_pc4,
  output logic                o_id_trap
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] trap_pc;
  logic            trap_pending;
  logic            redirect_misaligned;
  logic            ifid_load;
  logic            ifid_clear;
  ifid_t           ifid_d;
  ifid_t           ifid_q;

  assign imem.imem_raddr = pc;
  assign pc_plus4        = pc + 32'd4;

  // With the trap disabled this is constant 0, so TRAP_HOLD is unreachable.
  assign redirect_misaligned = TRAP_EN && (i_redirect_pc[1:0] != 2'b00);

  // A misaligned redirect takes two edges: the first kills IF/ID and parks
  // PC on the aligned word, the second (trap_pending) captures the trap
  // entry carrying the original unmasked target.
  always_comb begin
    ifid_load       = 1'b0;
    ifid_clear      = 1'b0;
    ifid_d.valid    = 1'b1;
    ifid_d.inst     = imem.imem_rdata;
    ifid_d.pc       = pc;
    ifid_d.pc4      = pc_plus4;
    ifid_d.trap     = 1'b0;
    if (i_redirect_valid) begin
      ifid_clear = 1'b1;
    end else if (trap_pending) begin
      ifid_load   = 1'b1;
      ifid_d.pc   = trap_pc;
      ifid_d.pc4  = trap_pc + 32'd4;
      ifid_d.trap = 1'b1;
    end else if (state == TRAP_HOLD) begin
      ifid_load = 1'b0;
    end else if (i_flush) begin
      ifid_clear = 1'b1;
    end else if (!i_stall) begin
      ifid_load = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= RUN;
      pc           <= word_align(RESET_ADDR);
      trap_pc      <= '0;
      trap_pending <= 1'b0;
    end else if (i_redirect_valid) begin
      pc           <= word_align(i_redirect_pc);
      trap_pc      <= i_redirect_pc;
      trap_pending <= redirect_misaligned;
      state        <= redirect_misaligned ? TRAP_HOLD : RUN;
    end else if (state == TRAP_HOLD) begin
      trap_pending <= 1'b0;
    end else if (!i_stall) begin
      pc <= pc_plus4;
    end
  end

  ifid_pipe_reg u_ifid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ifid_load),
    .i_clear (ifid_clear),
    .i_d     (ifid_d),
    .o_q     (ifid_q)
  );

  assign o_id_valid = ifid_q.valid;
  assign o_id_inst  = ifid_q.inst;
  assign o_id_pc    = ifid_q.pc;
  assign o_id_pc4   = ifid_q.pc4;
  assign o_id_trap  = ifid_q.trap & TRAP_EN;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// redirect/stall/flush/reset traffic against a rule-level reference model.
module tb_fetch_stage;
  import rv32i_pkg::*;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_id_valid;
  logic [31:0] o_id_inst;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_pc4;
  logic        o_id_trap;

  fetch_stage_if imem_bus ();

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_raddr);

  fetch_stage #(.RESET_ADDR(RST_PC)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .imem             (imem_bus.master),
    .i_stall          (i_stall),
    .i_flush          (i_flush),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_id_valid       (o_id_valid),
    .o_id_inst        (o_id_inst),
    .o_id_pc          (o_id_pc),
    .o_id_pc4         (o_id_pc4),
    .o_id_trap        (o_id_trap)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model state
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_inst, m_id_pc, m_pc4;
  bit          m_trap;
  bit          m_known;    // pc/pc4 of IF/ID are defined
  bit          m_hold;     // parked after a misaligned redirect
  bit          m_pend;     // trap entry still to be captured
  logic [31:0] m_tgt;

  task automatic model_apply(input bit rst, input bit stall, input bit flush,
                             input bit rv, input logic [31:0] rpc);
    bit mis;
    if (rst) begin
      m_pc = RST_PC; m_valid = 0; m_inst = NOP; m_id_pc = 0; m_pc4 = 0;
      m_trap = 0; m_known = 1; m_hold = 0; m_pend = 0;
    end else if (rv) begin
      mis = TRAP_EN && (rpc % 4 != 0);
      m_pc = rpc - (rpc % 4);
      m_valid = 0; m_inst = NOP; m_trap = 0; m_known = 0;
      m_hold = mis; m_pend = mis; m_tgt = rpc;
    end else if (m_pend) begin
      m_valid = 1; m_inst = mem_word(m_pc); m_id_pc = m_tgt; m_pc4 = m_tgt + 4;
      m_trap = 1; m_known = 1; m_pend = 0;
    end else if (m_hold) begin
      // parked: nothing moves until a redirect or reset
    end else if (flush) begin
      m_valid = 0; m_inst = NOP; m_trap = 0; m_known = 0;
      if (!stall) m_pc = m_pc + 4;
    end else if (!stall) begin
      m_valid = 1; m_inst = mem_word(m_pc); m_id_pc = m_pc; m_pc4 = m_pc + 4;
      m_trap = 0; m_known = 1; m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".raddr"}, imem_bus.imem_raddr, m_pc);
    check({tag, ".valid"}, 32'(o_id_valid), 32'(m_valid));
    check({tag, ".inst"},  o_id_inst, m_inst);
    check({tag, ".trap"},  32'(o_id_trap), 32'(m_trap));
    if (m_known) begin
      check({tag, ".pc"},  o_id_pc, m_id_pc);
      check({tag, ".pc4"}, o_id_pc4, m_pc4);
    end
  endtask

  task automatic step(input string tag, input bit rst, input bit stall, input bit flush,
                      input bit rv, input logic [31:0] rpc);
    i_rst = rst; i_stall = stall; i_flush = flush;
    i_redirect_valid = rv; i_redirect_pc = rpc;
    @(posedge i_clk);
    model_apply(rst, stall, flush, rv, rpc);
    #1;
    compare_all(tag);
  endtask

  initial begin
    // Reset with stall and redirect also asserted: reset wins
    step("rst0", 1, 1, 0, 1, 32'h0000_0400);
    step("rst1", 1, 0, 1, 0, 32'h0);
    check("rst_raddr", imem_bus.imem_raddr, 32'h0000_1000);
    check("rst_valid", 32'(o_id_valid), 32'd0);
    check("rst_inst", o_id_inst, 32'h0000_0013);
    check("rst_pc", o_id_pc, 32'h0);
    check("rst_pc4", o_id_pc4, 32'h0);

    step("first", 0, 0, 0, 0, 32'h0);
    check("first_valid", 32'(o_id_valid), 32'd1);
    check("first_pc", o_id_pc, 32'h0000_1000);
    check("first_pc4", o_id_pc4, 32'h0000_1004);

    step("run", 0, 0, 0, 0, 32'h0);
    for (int unsigned k = 0; k < 3; k++) begin
      step("stall", 0, 1, 0, 0, 32'h0);
      check("stall_raddr", imem_bus.imem_raddr, 32'h0000_1008);
      check("stall_pc", o_id_pc, 32'h0000_1004);
    end
    step("unstall", 0, 0, 0, 0, 32'h0);
    check("unstall_pc", o_id_pc, 32'h0000_1008);

    step("redir_prio", 0, 1, 0, 1, 32'h0000_0200);
    check("redir_raddr", imem_bus.imem_raddr, 32'h0000_0200);
    check("redir_valid", 32'(o_id_valid), 32'd0);
    check("redir_inst", o_id_inst, 32'h0000_0013);

    step("wrap_redir", 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0, 32'h0);
    check("wrap_raddr", imem_bus.imem_raddr, 32'h0);
    check("wrap_pc", o_id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", o_id_pc4, 32'h0);

    step("mis_redir", 0, 0, 0, 1, 32'h0000_0102);
    check("mis_raddr", imem_bus.imem_raddr, 32'h0000_0100);
    step("mis_next", 0, 0, 0, 0, 32'h0);
    if (TRAP_EN) begin
      check("mis_trap", 32'(o_id_trap), 32'd1);
      check("mis_pc", o_id_pc, 32'h0000_0102);
      step("mis_hold0", 0, 0, 0, 0, 32'h0);
      step("mis_hold1", 0, 0, 1, 0, 32'h0);
      check("mis_hold_raddr", imem_bus.imem_raddr, 32'h0000_0100);
      step("mis_exit", 0, 0, 0, 1, 32'h0000_0300);
      step("mis_resume", 0, 0, 0, 0, 32'h0);
      check("mis_resume_pc", o_id_pc, 32'h0000_0300);
    end else begin
      check("mis_trap", 32'(o_id_trap), 32'd0);
      check("mis_pc", o_id_pc, 32'h0000_0100);
    end

    step("pre_flush", 0, 0, 0, 0, 32'h0);
    begin
      logic [31:0] held;
      held = imem_bus.imem_raddr;
      step("flush_stall", 0, 1, 1, 0, 32'h0);
      check("flush_valid", 32'(o_id_valid), 32'd0);
      check("flush_raddr", imem_bus.imem_raddr, held);
    end

    // Randomized traffic, including occasional reset mid-stall / mid-hold
    for (int unsigned n = 0; n < 600; n++) begin
      bit          r_rst, r_st, r_fl, r_rv;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < 30);
      r_fl  = ($urandom_range(0, 99) < 12);
      r_rv  = ($urandom_range(0, 99) < 12);
      r_pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      if ($urandom_range(0, 1) == 1) r_pc[1:0] = 2'b00;
      step("rand", r_rst, r_st, r_fl, r_rv, r_pc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h00000000: PC value loaded on reset.
REQ-002 SHALL have port i_clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port o_imem_raddr, output, 32: imem read address; bits [1:0] always 2'b00.
REQ-005 SHALL have port i_imem_rdata, input, 32: instruction word, returned combinationally for o_imem_raddr.
REQ-006 SHALL have port i_stall, input, 1: decode cannot accept; hold PC and IF/ID.
REQ-007 SHALL have port i_flush, input, 1: kill the current IF/ID entry.
REQ-008 SHALL have port i_redirect_valid, input, 1: taken branch/jump resolved downstream.
REQ-009 SHALL have port i_redirect_pc, input, 32: redirect target.
REQ-010 SHALL have port o_id_valid, output, 1: IF/ID holds a live instruction.
REQ-011 SHALL have port o_id_inst, output, 32: IF/ID instruction word, unmodified.
REQ-012 SHALL have port o_id_pc, output, 32: fetch address of o_id_inst.
REQ-013 SHALL have port o_id_pc4, output, 32: o_id_pc + 4, modulo 2^32.
REQ-014 SHALL have port o_id_trap, output, 1: misaligned fetch-target trap flag for the IF/ID entry.

Function
REQ-015 SHALL drive o_imem_raddr combinationally from the PC register, with no added latency.
REQ-016 SHALL, on a normal cycle (no redirect, no stall, no flush), load IF/ID with {valid=1, i_imem_rdata, PC, PC+4, trap=0} and advance PC to PC+4; fetch-to-IF/ID latency is 1 cycle.
REQ-017 SHALL, when i_stall=1 and neither redirect nor flush is asserted, hold PC and every IF/ID field unchanged.
REQ-018 SHALL, when i_redirect_valid=1, load PC with i_redirect_pc and load IF/ID with valid=0, inst=32'h00000013 (NOP), regardless of i_stall or i_flush.
REQ-019 SHALL, when i_flush=1 and there is no redirect, set IF/ID valid=0 and inst=NOP; PC advances by 4 if i_stall=0 and holds if i_stall=1.
REQ-020 SHALL compute PC+4 with wrap-around: 32'hFFFFFFFC advances to 32'h00000000.
REQ-021 SHALL implement the FSM RUN/TRAP_HOLD. RUN→TRAP_HOLD on a redirect whose target[1:0]≠0 (macro enabled only). TRAP_HOLD→RUN on an aligned redirect. TRAP_HOLD→TRAP_HOLD on a misaligned redirect.
REQ-022 SHALL, in TRAP_HOLD, hold PC and IF/ID; IF/ID holds the trap entry from REQ-029 until consumed.

Reset
REQ-023 SHALL, on i_rst=1 at a clock edge, set PC=RESET_ADDR, FSM=RUN, o_id_valid=0, o_id_inst=NOP, o_id_pc=0, o_id_pc4=0, o_id_trap=0.
REQ-024 SHALL give i_rst priority over redirect, stall and flush, including reset asserted mid-stall or in TRAP_HOLD.
REQ-025 SHALL present RESET_ADDR on o_imem_raddr in the first cycle after reset deasserts; the first valid IF/ID entry appears one edge later.

Configuration
REQ-026 SHALL support the macro FETCH_MISALIGN_TRAP_EN.
REQ-027 SHALL, with FETCH_MISALIGN_TRAP_EN undefined, clear target[1:0] on every redirect, never enter TRAP_HOLD, and tie o_id_trap to 0.
REQ-028 SHALL, with FETCH_MISALIGN_TRAP_EN defined, handle a misaligned redirect target as follows: load PC = {target[31:2],2'b00}, enter TRAP_HOLD, and on the next edge load IF/ID with {valid=1, inst=i_imem_rdata, pc=target (unmasked), pc4=target+4, trap=1}.
REQ-029 SHALL, with the macro defined, treat the IF/ID entry loaded per REQ-028 as the trap entry held in TRAP_HOLD.

Structure
REQ-030 SHALL take the NOP constant (32'h00000013), the XLEN=32 constant and the FSM state typedef from the shared package rv32i_pkg.
REQ-031 SHALL implement the IF/ID register as one sub-module, ifid_pipe_reg, with load/hold/clear controls; PC/FSM logic stays in fetch_stage.

Verification
REQ-032 SHALL verify reset: RESET_ADDR=32'h00001000, release i_rst -> o_imem_raddr=32'h00001000; next edge o_id_valid=1, o_id_pc=32'h00001000, o_id_pc4=32'h00001004.
REQ-033 SHALL verify stall: i_stall=1 for 3 cycles at PC 32'h00001008 -> PC and IF/ID unchanged; after release, the next o_id_pc=32'h00001008.
REQ-034 SHALL verify redirect priority: i_redirect_valid=1, i_redirect_pc=32'h00000200, i_stall=1 -> next cycle o_imem_raddr=32'h00000200, o_id_valid=0, o_id_inst=32'h00000013.
REQ-035 SHALL verify wrap-around: redirect to 32'hFFFFFFFC -> next fetch address 32'h00000000; the IF/ID entry for 32'hFFFFFFFC has o_id_pc4=32'h00000000.
REQ-036 SHALL verify a misaligned redirect to 32'h00000102: with the macro defined -> o_id_trap=1, o_id_pc=32'h00000102, PC held until an aligned redirect to 32'h00000300 restarts fetch; with the macro undefined -> fetch from 32'h00000100, o_id_trap=0.
REQ-037 SHALL verify flush during stall: i_flush=1 and i_stall=1 -> o_id_valid=0, PC unchanged.
